// File: rtl/io_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : io_mux_pkg
//  Description : Shared definitions for the Wishbone pad router: register
//                offsets, field positions, mode encoding, config structs and
//                word pack/unpack helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package io_mux_pkg;

    // Offsets inside the 4 KiB window
    localparam logic [11:0] PAD_BASE   = 12'h000;
    localparam logic [11:0] FIN_BASE   = 12'h400;
    localparam logic [11:0] COMMIT_OFS = 12'hFF8;
    localparam logic [11:0] STATUS_OFS = 12'hFFC;

    // Field bit positions in the config words
    localparam int MODE_LSB    = 0;
    localparam int OUT_SEL_LSB = 8;
    localparam int PAD_INV_BIT = 16;
    localparam int SRC_PAD_LSB = 0;
    localparam int FIN_INV_BIT = 8;

    typedef enum logic [1:0] {
        MODE_IN   = 2'b00,
        MODE_FUNC = 2'b01,
        MODE_LO   = 2'b10,
        MODE_HI   = 2'b11
    } mode_e;

    typedef struct packed {
        logic       invert;
        logic [7:0] out_sel;
        mode_e      mode;
    } pad_cfg_t;

    typedef struct packed {
        logic       invert;
        logic [7:0] src_pad;
    } fin_cfg_t;

    localparam pad_cfg_t PAD_CFG_RST = '{invert: 1'b0, out_sel: 8'h00, mode: MODE_IN};
    localparam fin_cfg_t FIN_CFG_RST = '{invert: 1'b0, src_pad: 8'hFF};

    // Replace only the bytes whose enable is set
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  sel);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] pad_to_word(input pad_cfg_t c);
        logic [31:0] w;
        w = '0;
        w[MODE_LSB +: 2]    = c.mode;
        w[OUT_SEL_LSB +: 8] = c.out_sel;
        w[PAD_INV_BIT]      = c.invert;
        return w;
    endfunction

    function automatic pad_cfg_t word_to_pad(input logic [31:0] w);
        pad_cfg_t c;
        c.mode    = mode_e'(w[MODE_LSB +: 2]);
        c.out_sel = w[OUT_SEL_LSB +: 8];
        c.invert  = w[PAD_INV_BIT];
        return c;
    endfunction

    function automatic logic [31:0] fin_to_word(input fin_cfg_t c);
        logic [31:0] w;
        w = '0;
        w[SRC_PAD_LSB +: 8] = c.src_pad;
        w[FIN_INV_BIT]      = c.invert;
        return w;
    endfunction

    function automatic fin_cfg_t word_to_fin(input logic [31:0] w);
        fin_cfg_t c;
        c.src_pad = w[SRC_PAD_LSB +: 8];
        c.invert  = w[FIN_INV_BIT];
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_mux_sync.sv
`default_nettype none
// ============================================================================
//  Module      : io_mux_sync
//  Description : Two-flop synchroniser, asynchronous active-high reset to 0.
//  Ports       : clk, rst      - clock / async reset
//                i_d [WIDTH]   - asynchronous input
//                o_q [WIDTH]   - synchronised output (2 cycles latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module io_mux_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/io_mux_router.sv
`default_nettype none
// ============================================================================
//  Module      : io_mux_router
//  Description : Wishbone-configurable router between core functions and user
//                pads. Config is staged in shadow registers, copied to the
//                active set on COMMIT, and can be locked until reset.
//  Ports       : wb_clk_i / wb_rst_i   - clock / async active-high reset
//                wbs_*                 - Wishbone classic slave
//                fout / fin            - core output / input functions
//                io_in / io_out / io_oeb - pad side
//                locked                - configuration lock status
//  Revision    : 1.0 - initial release
// ============================================================================
module io_mux_router
    import io_mux_pkg::*;
#(
    parameter int                N_PADS      = 38,
    parameter int                N_FOUT      = 24,
    parameter int                N_FIN       = 16,
    parameter logic [31:0]       BASE_ADR    = 32'h3000_0000,
    parameter logic [N_FIN-1:0]  FIN_DEFAULT = '0
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic [N_FOUT-1:0] fout,
    output logic [N_FIN-1:0]  fin,
    input  logic [N_PADS-1:0] io_in,
    output logic [N_PADS-1:0] io_out,
    output logic [N_PADS-1:0] io_oeb,
    output logic              locked
);

    localparam logic [8:0] C_N_PADS = 9'(N_PADS);
    localparam logic [8:0] C_N_FIN  = 9'(N_FIN);

    logic              r_ack;
    logic [31:0]       r_dat;
    logic              r_locked;
    logic              r_pending;
    pad_cfg_t          r_pad_shd [N_PADS];
    pad_cfg_t          r_pad_act [N_PADS];
    fin_cfg_t          r_fin_shd [N_FIN];
    fin_cfg_t          r_fin_act [N_FIN];
    logic [N_PADS-1:0] r_io_out;
    logic [N_PADS-1:0] r_io_oeb;
    logic [N_FIN-1:0]  r_fin;

    logic [N_PADS-1:0] w_io_sync;
    logic [255:0]      w_fout_ext;
    logic [255:0]      w_in_ext;
    logic [11:0]       w_ofs;
    logic [7:0]        w_idx;
    logic              w_in_win;
    logic              w_req;
    logic              w_pad_hit;
    logic              w_fin_hit;
    logic              w_wr_ok;
    logic              w_cfg_wr;
    logic              w_commit;
    logic              w_lock;
    logic [31:0]       w_rdata;
    logic [N_PADS-1:0] w_io_out_nxt;
    logic [N_PADS-1:0] w_io_oeb_nxt;
    logic [N_FIN-1:0]  w_fin_nxt;
    logic              w_unused;

    io_mux_sync #(.WIDTH(N_PADS)) u_sync (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .i_d (io_in),
        .o_q (w_io_sync)
    );

    // Zero-extended to 256 so any 8-bit selector indexes safely; selectors
    // past N_FOUT therefore read 0 and the pad drives just the invert bit.
    assign w_fout_ext = 256'(fout);
    assign w_in_ext   = 256'(w_io_sync);

    // ---------------------------------------------------------------- decode
    assign w_in_win  = (wbs_adr_i[31:12] == BASE_ADR[31:12]);
    assign w_ofs     = wbs_adr_i[11:0];
    assign w_idx     = w_ofs[9:2];
    assign w_unused  = &{1'b0, wbs_adr_i[1:0]};

    // ~r_ack blocks a second access on the cycle right after an ack
    assign w_req     = wbs_stb_i & wbs_cyc_i & w_in_win & ~r_ack;
    assign w_pad_hit = (w_ofs[11:10] == PAD_BASE[11:10]) && ({1'b0, w_idx} < C_N_PADS);
    assign w_fin_hit = (w_ofs[11:10] == FIN_BASE[11:10]) && ({1'b0, w_idx} < C_N_FIN);
    assign w_wr_ok   = w_req & wbs_we_i & ~r_locked;
    assign w_cfg_wr  = w_wr_ok & (w_pad_hit | w_fin_hit);
    assign w_commit  = w_wr_ok & (w_ofs == COMMIT_OFS) & wbs_sel_i[0] & wbs_dat_i[0];
    assign w_lock    = w_wr_ok & (w_ofs == STATUS_OFS) & wbs_sel_i[0] & wbs_dat_i[0];

    always_comb begin
        w_rdata = '0;
        if (w_pad_hit) begin
            for (int i = 0; i < N_PADS; i++) begin
                if (w_idx == 8'(i)) w_rdata = pad_to_word(r_pad_shd[i]);
            end
        end else if (w_fin_hit) begin
            for (int f = 0; f < N_FIN; f++) begin
                if (w_idx == 8'(f)) w_rdata = fin_to_word(r_fin_shd[f]);
            end
        end else if (w_ofs == STATUS_OFS) begin
            w_rdata = {30'b0, r_pending, r_locked};
        end
    end

    // ------------------------------------------------------- Wishbone slave
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack     <= 1'b0;
            r_dat     <= '0;
            r_locked  <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_ack <= w_req;
            r_dat <= (w_req & ~wbs_we_i) ? w_rdata : '0;
            if (w_lock) r_locked <= 1'b1;
            if (w_commit)      r_pending <= 1'b0;
            else if (w_cfg_wr) r_pending <= 1'b1;
        end
    end

    // ------------------------------------------------- shadow / active sets
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < N_PADS; i++) begin
                r_pad_shd[i] <= PAD_CFG_RST;
                r_pad_act[i] <= PAD_CFG_RST;
            end
            for (int f = 0; f < N_FIN; f++) begin
                r_fin_shd[f] <= FIN_CFG_RST;
                r_fin_act[f] <= FIN_CFG_RST;
            end
        end else begin
            for (int i = 0; i < N_PADS; i++) begin
                if (w_cfg_wr && w_pad_hit && (w_idx == 8'(i)))
                    r_pad_shd[i] <= word_to_pad(merge_bytes(pad_to_word(r_pad_shd[i]),
                                                            wbs_dat_i, wbs_sel_i));
                if (w_commit) r_pad_act[i] <= r_pad_shd[i];
            end
            for (int f = 0; f < N_FIN; f++) begin
                if (w_cfg_wr && w_fin_hit && (w_idx == 8'(f)))
                    r_fin_shd[f] <= word_to_fin(merge_bytes(fin_to_word(r_fin_shd[f]),
                                                            wbs_dat_i, wbs_sel_i));
                if (w_commit) r_fin_act[f] <= r_fin_shd[f];
            end
        end
    end

    // ---------------------------------------------------------- routing mux
    always_comb begin
        w_io_out_nxt = '0;
        w_io_oeb_nxt = '1;
        for (int i = 0; i < N_PADS; i++) begin
            case (r_pad_act[i].mode)
                MODE_FUNC: begin
                    w_io_oeb_nxt[i] = 1'b0;
                    w_io_out_nxt[i] = w_fout_ext[r_pad_act[i].out_sel] ^ r_pad_act[i].invert;
                end
                MODE_LO: begin
                    w_io_oeb_nxt[i] = 1'b0;
                    w_io_out_nxt[i] = 1'b0;
                end
                MODE_HI: begin
                    w_io_oeb_nxt[i] = 1'b0;
                    w_io_out_nxt[i] = 1'b1;
                end
                default: begin
                    w_io_oeb_nxt[i] = 1'b1;
                    w_io_out_nxt[i] = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_fin_nxt = FIN_DEFAULT;
        for (int f = 0; f < N_FIN; f++) begin
            if ({1'b0, r_fin_act[f].src_pad} < C_N_PADS)
                w_fin_nxt[f] = w_in_ext[r_fin_act[f].src_pad] ^ r_fin_act[f].invert;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_io_out <= '0;
            r_io_oeb <= '1;
            r_fin    <= FIN_DEFAULT;
        end else begin
            r_io_out <= w_io_out_nxt;
            r_io_oeb <= w_io_oeb_nxt;
            r_fin    <= w_fin_nxt;
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign io_out    = r_io_out;
    assign io_oeb    = r_io_oeb;
    assign fin       = r_fin;
    assign locked    = r_locked;

endmodule
`default_nettype wire
